// File: rtl/inst_fetch_queue_if.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue_if
//   Groups the instruction-memory bus, the redirect/decode side-band and the
//   decode-facing queue head of the fetch unit into one bundle.
//
//   Handshakes:
//     imem_req/imem_gnt : a request transfers in a cycle where both are high;
//                         while imem_req is high and imem_gnt low, imem_addr
//                         stays stable (only a redirect may retarget it).
//     imem_rvalid       : one in-order response per granted request, never in
//                         the grant cycle itself; it is always accepted.
//     inst_valid/stall  : the queue head transfers to decode in a cycle with
//                         inst_valid high and stall_id low.
//
//   Modports:
//     master : the fetch unit (drives imem_req/imem_addr and the queue head)
//     slave  : memory + pipeline environment
//   fq_state exposes the fetch FSM state (0 FETCH, 1 DRAIN, 2 HALT).
// -----------------------------------------------------------------------------
interface inst_fetch_queue_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall_id;
    logic        inst_valid;
    logic [31:0] inst_raw;
    logic [31:0] inst_pc;
    logic        misalign;
    logic [1:0]  fq_state;

    modport master (
        output imem_req, imem_addr, inst_valid, inst_raw, inst_pc, misalign, fq_state,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, stall_id
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst_raw, inst_pc, misalign, fq_state,
        output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, stall_id
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue
//   Instruction fetch unit with a small in-order instruction queue. Issues
//   word-aligned fetches from a fetch PC, tracks outstanding requests so the
//   queue can never overflow, and flushes/drains on branch redirects.
//
//   Parameters:
//     RESET_PC : first fetch address after reset
//     FQ_DEPTH : queue entries (power of 2, >= 2)
//
//   Ports:
//     clk  : clock, all state updates on rising edge
//     rst  : synchronous active-high reset
//     bus  : inst_fetch_queue_if.master (imem req/gnt/rvalid bus, redirect,
//            stall_id, queue head inst_valid/inst_raw/inst_pc, misalign,
//            fq_state debug)
//
//   Optional feature macro: FETCH_MISALIGN_TRAP_EN
//     defined   : a redirect to a non word-aligned target halts fetching and
//                 sets a sticky misalign flag until an aligned redirect.
//     undefined : redirect_pc[1:0] is ignored (forced 0), misalign is 0.
// -----------------------------------------------------------------------------
module inst_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned FQ_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    inst_fetch_queue_if.master  bus
);

    localparam int unsigned AW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FQ_DEPTH + 1);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } fq_state_e;

    fq_state_e      state_q, state_d;
    logic [31:0]    fpc_q, fpc_d;
    logic [CW-1:0]  occ_q;
    logic [CW-1:0]  outst_q, outst_d;
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [31:0]    pc_mem   [FQ_DEPTH];
    logic [31:0]    data_mem [FQ_DEPTH];

    logic           room;
    logic           req;
    logic           grant;
    logic           rsp;
    logic           push;
    logic           pop;
    logic [31:0]    push_pc;
    logic [31:0]    tgt_pc;
    logic           tgt_misaligned;

    // ------------------------------------------------------------------
    // Redirect target handling
    // ------------------------------------------------------------------
`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;

    assign tgt_pc         = bus.redirect_pc;
    assign tgt_misaligned = (bus.redirect_pc[1:0] != 2'b00);
    assign bus.misalign   = misalign_q;
`else
    assign tgt_pc         = bus.redirect_pc & 32'hFFFF_FFFC;
    assign tgt_misaligned = 1'b0;
    assign bus.misalign   = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Request / response bookkeeping
    // ------------------------------------------------------------------
    // Credit rule: every granted request already owns a queue slot, so
    // responses can always be pushed without back-pressure.
    assign room  = ({1'b0, occ_q} + {1'b0, outst_q}) < (CW+1)'(FQ_DEPTH);
    assign req   = !rst && (state_q == FETCH) && room;
    assign grant = req && bus.imem_gnt;
    // Guard against a stray rvalid with nothing outstanding.
    assign rsp   = bus.imem_rvalid && (outst_q != '0);

    assign outst_d = outst_q + CW'(grant) - CW'(rsp);

    // In FETCH every outstanding request belongs to the current fetch
    // stream, issued back to back ending at fpc-4, so the oldest one
    // (the one this response answers) sits at fpc - 4*outstanding.
    assign push_pc = fpc_q - 32'({outst_q, 2'b00});

    // Redirect beats same-cycle push and pop.
    assign push = rsp && (state_q == FETCH) && !bus.redirect_valid;
    assign pop  = (occ_q != '0) && !bus.stall_id && !bus.redirect_valid;

    // ------------------------------------------------------------------
    // FSM next state / fetch PC
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        fpc_d   = fpc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        misalign_d = misalign_q;
`endif
        if (bus.redirect_valid) begin
            fpc_d = tgt_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_d = tgt_misaligned;
`endif
        end else if (grant) begin
            fpc_d = fpc_q + 32'd4;
        end

        case (state_q)
            FETCH: begin
                if (bus.redirect_valid) begin
                    if (tgt_misaligned)
                        state_d = HALT;
                    else if (outst_d != '0)
                        state_d = DRAIN;
                end
            end
            DRAIN: begin
                // A redirect here only retargets fpc; the discard count is
                // the outstanding count, which only rvalid decrements.
                if (bus.redirect_valid && tgt_misaligned)
                    state_d = HALT;
                else if (outst_d == '0)
                    state_d = FETCH;
            end
            HALT: begin
                // Outstanding responses keep being dropped while halted.
                if (bus.redirect_valid && !tgt_misaligned)
                    state_d = (outst_d != '0) ? DRAIN : FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FETCH;
            fpc_q    <= RESET_PC;
            outst_q  <= '0;
            occ_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q <= state_d;
            fpc_q   <= fpc_d;
            outst_q <= outst_d;
            if (bus.redirect_valid) begin
                occ_q    <= '0;
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                occ_q <= occ_q + CW'(push) - CW'(pop);
                if (push)
                    wr_ptr_q <= wr_ptr_q + AW'(1);
                if (pop)
                    rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst)
            misalign_q <= 1'b0;
        else
            misalign_q <= misalign_d;
    end
`endif

    // Queue storage needs no reset: occupancy decides what is valid.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            pc_mem[wr_ptr_q]   <= push_pc;
            data_mem[wr_ptr_q] <= bus.imem_rdata;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.imem_req   = req;
    assign bus.imem_addr  = rst ? RESET_PC : fpc_q;
    assign bus.inst_valid = !rst && (occ_q != '0);
    assign bus.inst_raw   = data_mem[rd_ptr_q];
    assign bus.inst_pc    = pc_mem[rd_ptr_q];
    assign bus.fq_state   = state_q;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_queue
//   Directed + randomized bench for inst_fetch_queue. A small in-order memory
//   model answers granted fetches; a scoreboard holds the PCs decode should
//   see next and checks every instruction handed to decode.
// -----------------------------------------------------------------------------
module tb_inst_fetch_queue;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk;
    logic rst;

    inst_fetch_queue_if bus ();

    inst_fetch_queue #(
        .RESET_PC (RESET_PC),
        .FQ_DEPTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- bench state ----------------
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    int          cyc = 0;
    bit          gnt_always = 1'b1;
    int          lat_min = 1;
    int          lat_max = 1;
    int          pops = 0;
    int          grants = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A3C_0F96;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push_seq(input logic [31:0] start, input int n);
        logic [31:0] p;
        p = start;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(p);
            p = p + 32'd4;
        end
    endtask

    // One clock cycle: observe at negedge, then drive memory after posedge.
    task automatic tick();
        logic [31:0] e;
        @(negedge clk);
        if (!rst) begin
            if (bus.inst_valid && !bus.stall_id && !bus.redirect_valid) begin
                pops++;
                if (exp_q.size() == 0) begin
                    check("unexpected_pop", 32'(bus.inst_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("inst_pc", bus.inst_pc, e);
                    check("inst_raw", bus.inst_raw, mem_word(e));
                end
            end
            if (bus.imem_rvalid && pend_addr.size() > 0) begin
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end
            if (bus.imem_req && bus.imem_gnt) begin
                pend_addr.push_back(bus.imem_addr);
                pend_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
                grants++;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            pend_addr.delete();
            pend_due.delete();
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = 32'($urandom);
        end else if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mem_word(pend_addr[0]);
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = 32'($urandom);
        end
        bus.imem_gnt = gnt_always ? 1'b1 : 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        exp_q.delete();
        tick();
        tick();
        check("rst_imem_req",   32'(bus.imem_req),   32'd0);
        check("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
        check("rst_imem_addr",  bus.imem_addr,       RESET_PC);
        check("rst_misalign",   32'(bus.misalign),   32'd0);
        check("rst_state",      32'(bus.fq_state),   32'd0);
        rst    = 1'b0;
        cyc    = 0;
        grants = 0;
        pops   = 0;
        push_seq(RESET_PC, 200);
    endtask

    task automatic do_redirect(input logic [31:0] tgt, input logic [31:0] start,
                               input int n, output int disc);
        disc = pend_addr.size() + ((bus.imem_req && bus.imem_gnt) ? 1 : 0)
                                - (bus.imem_rvalid ? 1 : 0);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = tgt;
        tick();
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'($urandom);
        exp_q.delete();
        push_seq(start, n);
        check("redir_flush_valid", 32'(bus.inst_valid), 32'd0);
    endtask

    task automatic wait_first_pop(input string tag, input logic [31:0] pc);
        int n;
        n = 0;
        while (!(bus.inst_valid && !bus.stall_id) && n < 60) begin
            tick();
            n++;
        end
        check(tag, (n < 60) ? bus.inst_pc : 32'hDEAD_0000, pc);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int disc;
        int drops;
        int n;
        int reqs;

        rst                = 1'b1;
        bus.imem_gnt       = 1'b0;
        bus.imem_rvalid    = 1'b0;
        bus.imem_rdata     = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.stall_id       = 1'b0;

        // Streaming: gnt always, 1-cycle latency, no stall.
        gnt_always = 1'b1; lat_min = 1; lat_max = 1;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            check("stream_valid", 32'(bus.inst_valid), (i >= 2) ? 32'd1 : 32'd0);
            if (i >= 2)
                check("stream_pc", bus.inst_pc, 32'(4 * (i - 2)));
            tick();
        end
        repeat (10) tick();

        // Decode stalled for 10 cycles: queue fills, fetch stops.
        bus.stall_id = 1'b1;
        do_reset();
        repeat (10) tick();
        check("stall_req",    32'(bus.imem_req),   32'd0);
        check("stall_valid",  32'(bus.inst_valid), 32'd1);
        check("stall_pc",     bus.inst_pc,         32'h0);
        check("stall_grants", 32'(grants),         32'd4);
        bus.stall_id = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("unstall_valid", 32'(bus.inst_valid), 32'd1);
            check("unstall_pc",    bus.inst_pc,         32'(4 * k));
            tick();
        end
        repeat (6) tick();

        // Redirect with two requests in flight: drain then restart.
        lat_min = 2; lat_max = 2;
        do_reset();
        repeat (8) tick();
        do_redirect(32'h100, 32'h100, 200, disc);
        check("drain_disc",  32'(disc),          32'd2);
        check("drain_state", 32'(bus.fq_state),  32'd1);
        check("drain_req",   32'(bus.imem_req),  32'd0);
        drops = 0; n = 0;
        while (bus.fq_state == 2'd1 && n < 50) begin
            if (bus.imem_rvalid) drops++;
            tick();
            n++;
        end
        check("drain_exit_state", 32'(bus.fq_state), 32'd0);
        check("drain_drops",      32'(drops),        32'(disc));
        wait_first_pop("drain_first_pc", 32'h100);
        repeat (10) tick();

        // Redirect in a cycle that also pops and pushes.
        lat_min = 1; lat_max = 1;
        do_reset();
        repeat (6) tick();
        check("pp_inst_valid", 32'(bus.inst_valid),  32'd1);
        check("pp_rvalid",     32'(bus.imem_rvalid), 32'd1);
        do_redirect(32'h100, 32'h100, 200, disc);
        wait_first_pop("pp_first_pc", 32'h100);
        repeat (8) tick();

        // PC wrap at the top of the address space.
        do_redirect(32'hFFFF_FFF8, 32'hFFFF_FFF8, 200, disc);
        n = 0;
        while (!(bus.imem_req && bus.imem_gnt && bus.imem_addr == 32'hFFFF_FFFC) && n < 40) begin
            tick();
            n++;
        end
        check("wrap_seen", 32'(n < 40), 32'd1);
        tick();
        check("wrap_addr", bus.imem_addr, 32'h0);
        repeat (12) tick();

        // Misaligned redirect.
`ifdef FETCH_MISALIGN_TRAP_EN
        do_redirect(32'h102, 32'h0, 0, disc);
        check("mis_flag",  32'(bus.misalign), 32'd1);
        check("mis_state", 32'(bus.fq_state), 32'd2);
        reqs = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.imem_req) reqs++;
            tick();
        end
        check("mis_no_req", 32'(reqs),           32'd0);
        check("mis_valid",  32'(bus.inst_valid), 32'd0);
        check("mis_sticky", 32'(bus.misalign),   32'd1);
        do_redirect(32'h200, 32'h200, 200, disc);
        check("mis_clear", 32'(bus.misalign), 32'd0);
        wait_first_pop("mis_resume_pc", 32'h200);
`else
        reqs = 0;
        do_redirect(32'h102, 32'h100, 200, disc);
        check("mis_flag_off", 32'(bus.misalign), 32'd0);
        wait_first_pop("mis_forced_pc", 32'h100);
`endif
        repeat (8) tick();

        // Reset while draining: in-flight responses must vanish.
        lat_min = 3; lat_max = 3;
        do_reset();
        repeat (7) tick();
        do_redirect(32'h400, 32'h400, 200, disc);
        do_reset();
        wait_first_pop("rst_mid_first_pc", RESET_PC);
        repeat (10) tick();

        // Random grant, latency and stall with occasional redirects.
        gnt_always = 1'b0; lat_min = 1; lat_max = 3;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            bus.stall_id = ($urandom_range(0, 9) < 3);
            if (i == 80 || i == 160 || i == 240) begin
                logic [31:0] t;
                t = 32'($urandom) & 32'hFFFF_FFFC;
                do_redirect(t, t, 200, disc);
            end else begin
                tick();
            end
        end
        check("rand_pops_nonzero", 32'(pops > 0), 32'd1);
        bus.stall_id = 1'b0;
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch_queue.md
INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter FQ_DEPTH, default 4: instruction queue entries; power of 2, at least 2.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port imem_req, output, 1: fetch request valid.
REQ-006 SHALL have port imem_addr, output, 32: fetch address, word aligned.
REQ-007 SHALL have port imem_gnt, input, 1: request accepted this cycle.
REQ-008 SHALL have port imem_rvalid, input, 1: in-order response valid, at least 1 cycle after its grant.
REQ-009 SHALL have port imem_rdata, input, 32: response instruction word.
REQ-010 SHALL have port redirect_valid, input, 1: branch/jump redirect from EX.
REQ-011 SHALL have port redirect_pc, input, 32: redirect target.
REQ-012 SHALL have port stall_id, input, 1: decode stage not accepting.
REQ-013 SHALL have port inst_valid, output, 1: queue head valid for decode.
REQ-014 SHALL have port inst_raw, output, 32: queue head instruction (drives decoder inst_raw).
REQ-015 SHALL have port inst_pc, output, 32: PC of queue head.
REQ-016 SHALL have port misalign, output, 1: misaligned redirect flag (see Configuration).

Function
REQ-017 SHALL keep fetch PC register fpc; imem_addr = fpc; fpc += 4 on imem_req && imem_gnt, wrapping modulo 2^32.
REQ-018 SHALL count outstanding requests (granted, response pending) and assert imem_req in FETCH only when queue occupancy + outstanding < FQ_DEPTH.
REQ-019 SHALL push {fpc_of_request, imem_rdata} into queue on imem_rvalid unless discarding; overflow is impossible by REQ-018.
REQ-020 SHALL pop head when inst_valid && !stall_id; push and pop in same cycle keep occupancy unchanged.
REQ-021 SHALL drive inst_valid = queue not empty; inst_raw/inst_pc hold head contents, stable while stall_id.
REQ-022 SHALL implement FSM states FETCH, DRAIN, HALT.
REQ-023 On redirect_valid: queue flushed, fpc <= redirect_pc, inst_valid 0 next cycle; redirect has priority over same-cycle pop, push and PC increment.
REQ-024 On redirect, discard count = outstanding + same-cycle grant - same-cycle rvalid; if nonzero go DRAIN, else stay FETCH, imem_req with new PC next cycle.
REQ-025 In DRAIN SHALL hold imem_req 0, drop every response, decrement discard count per rvalid, return to FETCH when it reaches 0.
REQ-026 Redirect during DRAIN SHALL update fpc only; discard count unchanged except same-cycle rvalid decrement.
REQ-027 An unaccepted request may be withdrawn or retargeted only by redirect; otherwise imem_addr stable until imem_gnt.

Reset
REQ-028 On rst: fpc = RESET_PC, queue empty, outstanding = 0, discard = 0, state FETCH, misalign = 0.
REQ-029 Reset outputs: imem_req 0, inst_valid 0, imem_addr = RESET_PC; imem_req may assert from first cycle after rst deasserts.
REQ-030 Reset mid-operation SHALL abandon in-flight responses without pushing them; memory side is reset in the same cycle.

Configuration
REQ-031 Macro FETCH_MISALIGN_TRAP_EN defined: redirect with redirect_pc[1:0] != 0 enters HALT, sets misalign (sticky), issues no fetches; an aligned redirect clears misalign and resumes per REQ-024.
REQ-032 Macro undefined: redirect_pc[1:0] forced to 0, HALT unreachable, misalign tied 0.

Verification
REQ-033 Reset, gnt always 1, rvalid 1 cycle later, stall_id 0 -> inst_pc 0x0, 0x4, 0x8 on consecutive cycles starting cycle 3.
REQ-034 stall_id held 1 for 10 cycles -> exactly 4 entries queued, imem_req 0, inst_pc frozen at 0x0; release -> 0x0..0xC popped back to back.
REQ-035 Redirect to 0x100 with 2 outstanding -> DRAIN, 2 responses dropped, next inst_pc 0x100, no stale PC ever valid.
REQ-036 Redirect same cycle as pop and push -> queue empty next cycle, inst_valid 0, then 0x100 delivered.
REQ-037 With FETCH_MISALIGN_TRAP_EN, redirect to 0x102 -> misalign 1, no imem_req; redirect to 0x200 -> misalign 0, fetch 0x200.
REQ-038 fpc 0xFFFF_FFFC granted -> next imem_addr 0x0000_0000.
